// File: rtl/h_unlock_check.sv
// ----------------------------------------------------------------------------
// h_unlock_check
//
// Password verification stage of the digital lock. Each release of the
// confirm button compares the keypad entry against the stored password.
// A match opens the lock for UNLOCK_TICKS cycles. MAX_TRIES consecutive
// mismatches raise the alarm for LOCKOUT_TICKS cycles. Every output is
// registered.
//
// Ports:
//   clk_in          system clock
//   rst             synchronous, active-high reset
//   enb_check       check mode enabled (entries ignored while low)
//   disable_cnt     password edit in progress (entries ignored while high)
//   confirm_button  debounced confirm level; the release is the event
//   exit_button     debounced exit level; the release is the event
//   value_16bit     current keypad entry
//   password        stored password
//   unlocked        lock is open
//   alarm           lockout is active
//   fail_cnt        consecutive mismatches since last match/lockout/reset
//   ok_pulse        one-cycle strobe on a match
//   wrong_pulse     one-cycle strobe on a mismatch
// ----------------------------------------------------------------------------
module h_unlock_check #(
    parameter int UNLOCK_TICKS  = 500_000_000,
    parameter int LOCKOUT_TICKS = 1_500_000_000,
    parameter int MAX_TRIES     = 3
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        enb_check,
    input  logic        disable_cnt,
    input  logic        confirm_button,
    input  logic        exit_button,
    input  logic [15:0] value_16bit,
    input  logic [15:0] password,
    output logic        unlocked,
    output logic        alarm,
    output logic [1:0]  fail_cnt,
    output logic        ok_pulse,
    output logic        wrong_pulse
);

    localparam int MAX_TICKS = (UNLOCK_TICKS > LOCKOUT_TICKS) ? UNLOCK_TICKS : LOCKOUT_TICKS;
    // Guard against a zero-width timer for degenerate tick counts.
    localparam int TW = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_TICKS - 1);
    localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_TICKS - 1);
    localparam logic [2:0]    TRIES_LIMIT  = 3'(MAX_TRIES);

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_ALARM    = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic [1:0]      fail_cnt_reg, fail_cnt_next;
    logic            unlocked_reg, unlocked_next;
    logic            alarm_reg, alarm_next;
    logic            ok_pulse_reg, ok_pulse_next;
    logic            wrong_pulse_reg, wrong_pulse_next;
    logic            conf_q_reg, exit_q_reg;

    logic            confirm_evt, exit_evt, check_evt, is_match, timer_done;
    logic [2:0]      tries_after;

    // A press is acted on when the button is released (high then low).
    assign confirm_evt = conf_q_reg & ~confirm_button;
    assign exit_evt    = exit_q_reg & ~exit_button;
    assign check_evt   = confirm_evt & enb_check & ~disable_cnt;
    assign is_match    = (value_16bit == password);
    assign timer_done  = (timer_reg == '0);
    assign tries_after = {1'b0, fail_cnt_reg} + 3'd1;

    // State register plus all registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_reg       <= ST_LOCKED;
            timer_reg       <= '0;
            fail_cnt_reg    <= 2'd0;
            unlocked_reg    <= 1'b0;
            alarm_reg       <= 1'b0;
            ok_pulse_reg    <= 1'b0;
            wrong_pulse_reg <= 1'b0;
            conf_q_reg      <= 1'b0;
            exit_q_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            timer_reg       <= timer_next;
            fail_cnt_reg    <= fail_cnt_next;
            unlocked_reg    <= unlocked_next;
            alarm_reg       <= alarm_next;
            ok_pulse_reg    <= ok_pulse_next;
            wrong_pulse_reg <= wrong_pulse_next;
            conf_q_reg      <= confirm_button;
            exit_q_reg      <= exit_button;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_LOCKED: begin
                if (check_evt) begin
                    if (is_match)
                        state_next = ST_UNLOCKED;
                    else if (tries_after >= TRIES_LIMIT)
                        state_next = ST_ALARM;
                end
            end
            ST_UNLOCKED: begin
                // Exit and expiry both simply relock; coincidence is harmless.
                if (timer_done || exit_evt)
                    state_next = ST_LOCKED;
            end
            ST_ALARM: begin
                if (timer_done)
                    state_next = ST_LOCKED;
            end
            default: state_next = ST_LOCKED;
        endcase
    end

    // Output / datapath logic; results are captured by the register above.
    always_comb begin
        timer_next       = '0;
        fail_cnt_next    = fail_cnt_reg;
        ok_pulse_next    = 1'b0;
        wrong_pulse_next = 1'b0;
        case (state_reg)
            ST_LOCKED: begin
                if (check_evt) begin
                    if (is_match) begin
                        fail_cnt_next = 2'd0;
                        timer_next    = UNLOCK_LOAD;
                        ok_pulse_next = 1'b1;
                    end else if (tries_after >= TRIES_LIMIT) begin
                        fail_cnt_next    = 2'd0;
                        timer_next       = LOCKOUT_LOAD;
                        wrong_pulse_next = 1'b1;
                    end else begin
                        fail_cnt_next    = tries_after[1:0];
                        wrong_pulse_next = 1'b1;
                    end
                end
            end
            ST_UNLOCKED, ST_ALARM: begin
                // Count down while staying; leaving resets the timer to 0.
                if (state_next == state_reg && !timer_done)
                    timer_next = timer_reg - 1'b1;
            end
            default: timer_next = '0;
        endcase
        unlocked_next = (state_next == ST_UNLOCKED);
        alarm_next    = (state_next == ST_ALARM);
    end

    assign unlocked    = unlocked_reg;
    assign alarm       = alarm_reg;
    assign fail_cnt    = fail_cnt_reg;
    assign ok_pulse    = ok_pulse_reg;
    assign wrong_pulse = wrong_pulse_reg;

endmodule

// File: doc/h_unlock_check.md
# h_unlock_check

Password verification stage of the digital lock: it sits downstream of the new-password setter. It compares each confirmed 16-bit entry against the stored `password`. A match opens the lock for a fixed time. `MAX_TRIES` consecutive mismatches put the lock into a timed alarm lockout. All outputs are registered and drive the lock actuator, the alarm LED/buzzer and the attempt display.

## Interface
Parameters:
- `UNLOCK_TICKS`, default 500_000_000: number of clock cycles `unlocked` stays high.
- `LOCKOUT_TICKS`, default 1_500_000_000: number of clock cycles `alarm` stays high.
- `MAX_TRIES`, default 3: consecutive mismatches that trigger the alarm (range 1..3).

Ports:
- `clk_in`  in  1: system clock. One clock; reset is synchronous and active-high.
- `rst`  in  1: synchronous, active-high reset.
- `enb_check`  in  1: check mode is enabled. Entries are ignored while this is low.
- `disable_cnt`  in  1: from the setter; a password edit is in progress. Entries are ignored while this is high.
- `confirm_button`  in  1: debounced confirm button, active-high level.
- `exit_button`  in  1: debounced exit button, active-high level.
- `value_16bit`  in  16: current keypad entry.
- `password`  in  16: stored password from the setter.
- `unlocked`  out  1: lock is open.
- `alarm`  out  1: lockout is active.
- `fail_cnt`  out  2: consecutive mismatches since the last match, lockout or reset.
- `ok_pulse`  out  1: one-cycle strobe on a match.
- `wrong_pulse`  out  1: one-cycle strobe on a mismatch.

## Operation
- Release detection:
  - `conf_q` and `exit_q` register the previous button levels.
  - A confirm event is `conf_q & ~confirm_button`. An exit event is `exit_q & ~exit_button`.
  - Both registers reset to 0, so holding a button low through reset produces no event.
- States: LOCKED, UNLOCKED, ALARM. The state after reset is LOCKED.
- LOCKED, on a confirm event with `enb_check`=1 and `disable_cnt`=0:
  - The block compares `value_16bit == password`. These are sampled on the event edge; no prior latching.
  - Match: go to UNLOCKED, set `fail_cnt`=0, load `timer`=UNLOCK_TICKS-1, assert `ok_pulse`.
  - Mismatch with `fail_cnt`+1 < MAX_TRIES: increment `fail_cnt`, assert `wrong_pulse`, stay in LOCKED.
  - Mismatch with `fail_cnt`+1 == MAX_TRIES: go to ALARM, set `fail_cnt`=0, load `timer`=LOCKOUT_TICKS-1, assert `wrong_pulse`.
- LOCKED, other cases:
  - An exit event has no effect.
  - A confirm event with `enb_check`=0 or `disable_cnt`=1 is ignored, and `fail_cnt` holds.
- UNLOCKED:
  - `unlocked`=1 and `timer` decrements each cycle.
  - `timer`==0 or an exit event → LOCKED. An exit that coincides with `timer`==0 gives the same result.
  - Confirm events are ignored.
- ALARM:
  - `alarm`=1 and `timer` decrements each cycle.
  - `timer`==0 → LOCKED.
  - Confirm and exit events are ignored; only `rst` or expiry leaves ALARM.
- Timer width is `$clog2(max(UNLOCK_TICKS, LOCKOUT_TICKS))`. The timer never decrements below 0 and holds at 0 in LOCKED.
- A password of 0 (the setter's reset value) is valid: entry 0x0000 unlocks.
- Changes on `password` are taken as-is. They affect only the next compare and never re-evaluate the current state.

## Timing
- Reset (`rst`=1 at a rising edge):
  - State = LOCKED.
  - `unlocked`, `alarm`, `ok_pulse`, `wrong_pulse`, `fail_cnt`, `timer`, `conf_q` and `exit_q` are all 0.
  - Reset overrides any event in the same cycle.
  - Reset mid-UNLOCKED or mid-ALARM aborts immediately.
- Event latency:
  - An event is recognised at the first rising edge where the button is sampled low after being sampled high.
  - The state change, the pulses and `fail_cnt` are visible right after that same edge. That is one cycle after the low sample.
- Pulse width:
  - `ok_pulse` and `wrong_pulse` are exactly 1 cycle wide and never high together.
  - They are 0 in every cycle without an event.
- Hold times:
  - `unlocked` is high for exactly UNLOCK_TICKS cycles unless exit is used.
  - `alarm` is high for exactly LOCKOUT_TICKS cycles.
  - Back in LOCKED, the block accepts a confirm event in the very next cycle.
- A confirm event and an exit event in the same cycle: in LOCKED confirm is processed; in UNLOCKED exit wins; in ALARM both are ignored.
- Back-to-back confirm events, at least 2 cycles apart, are each processed.

## Test plan
Bench parameters: UNLOCK_TICKS=8, LOCKOUT_TICKS=16, MAX_TRIES=3, `password`=16'h1234, `enb_check`=1, `disable_cnt`=0.
- Correct entry: `value_16bit`=16'h1234, confirm release → `ok_pulse` for 1 cycle, `unlocked`=1 for exactly 8 cycles, then LOCKED with `fail_cnt`=0.
- Early exit: unlock, then exit release on the 3rd unlocked cycle → `unlocked`=0 on the next edge; a following confirm with 16'h1234 unlocks again.
- Wrong entries, then a match: two confirms with 16'h0000 → `wrong_pulse` ×2 and `fail_cnt` 1→2; a third confirm with 16'h1234 → unlock and `fail_cnt`=0.
- Alarm: three confirms with 16'hFFFF → `alarm`=1 for exactly 16 cycles and `fail_cnt`=0. During the alarm, a confirm with 16'h1234 and an exit are both ignored. After the alarm, a correct entry unlocks.
- Gating: `disable_cnt`=1 with a confirm of 16'hFFFF → no pulse and `fail_cnt` unchanged. Then `enb_check`=0 with a confirm of 16'h1234 → no unlock.
- Reset: assert `rst` on unlocked cycle 4 and, separately, on alarm cycle 5 → all outputs 0 next edge; holding confirm low through reset release gives no event.
